// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Purpose:
//   Two-entry valid/ready pipeline stage. A main register drives the output and
//   a skid register catches the one extra payload that can arrive in the cycle
//   the downstream side stalls. Because in_ready is registered (NOT skid-valid),
//   no combinational path runs from out_ready to in_ready. The upstream ready
//   path is therefore cut at this stage. Ordering is strict FIFO.
//
// Parameters:
//   PAYLOAD_BITS  width of the payload (all per-stage fields concatenated)
//   CNT_BITS      width of the backpressure stall counter
//   BUBBLE_ZERO   1: out_data is forced to zero while out_valid = 0
//
// Ports:
//   clk        in   1             single clock, rising edge
//   rst_       in   1             asynchronous active-low reset
//   flush      in   1             synchronous kill of all held entries
//   in_valid   in   1             upstream payload valid
//   in_ready   out  1             stage can accept a payload this cycle
//   in_data    in   PAYLOAD_BITS  upstream payload
//   out_valid  out  1             downstream payload valid
//   out_ready  in   1             downstream accepts this cycle
//   out_data   out  PAYLOAD_BITS  downstream payload
//   occupancy  out  2             number of held entries, 0..2
//   stall_cnt  out  CNT_BITS      saturating count of cycles with
//                                 out_valid=1 and out_ready=0
//                                 (only when PIPE_STALL_CNT_EN is defined)
//
// Configuration macro:
//   PIPE_STALL_CNT_EN  defined: stall_cnt port and counter are built.
//                      undefined: port and counter are absent; the data path
//                      behaves identically.
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int PAYLOAD_BITS = 160,
  parameter int CNT_BITS     = 16,
  parameter bit BUBBLE_ZERO  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic [1:0]              occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_BITS-1:0]     stall_cnt
`endif
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_main_valid;
  logic                    r_skid_valid;
  logic                    r_in_ready;
  logic [PAYLOAD_BITS-1:0] r_main_data;
  logic [PAYLOAD_BITS-1:0] r_skid_data;

  logic w_up_xfer;
  logic w_dn_xfer;

  // Handshakes are qualified only by registered state, so every decision
  // below is made from flop outputs plus the two external valid/ready inputs.
  assign w_up_xfer = in_valid & r_in_ready;
  assign w_dn_xfer = r_main_valid & out_ready;

  // ---------------------------------------------------------------------------
  // FSM and payload registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement
  // order; mixing in blocking assignments here would create order-dependent
  // simulation that no longer matches the synthesized netlist.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      // NOTE: the payload registers are reset too, even though the valid bits
      // alone would make them don't-care; out_data must read zero out of reset
      // even with BUBBLE_ZERO = 0, which needs a known main payload.
      r_state      <= ST_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      // Flush beats any same-cycle transfer: nothing is loaded and both
      // entries are dropped. Payload registers keep their stale contents; the
      // valid bits (and the bubble mux) make them invisible.
      r_state      <= ST_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_up_xfer) begin
            r_main_data  <= in_data;
            r_main_valid <= 1'b1;
            r_state      <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (w_up_xfer && w_dn_xfer) begin
            // Pass-through: the head leaves while the new payload replaces it.
            r_main_data <= in_data;
          end else if (w_dn_xfer) begin
            r_main_valid <= 1'b0;
            r_state      <= ST_EMPTY;
          end else if (w_up_xfer) begin
            // Downstream stalled in the same cycle we were still ready: the
            // skid register catches the payload and ready drops next cycle.
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
            r_state      <= ST_FULL;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so no upstream transfer can occur.
          if (w_dn_xfer) begin
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_state      <= ST_ONE;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          r_state      <= ST_EMPTY;
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all flop-driven except the optional bubble-zeroing mux.
  // ---------------------------------------------------------------------------
  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign occupancy = r_state;

  generate
    if (BUBBLE_ZERO) begin : g_bubble_zero
      assign out_data = r_main_valid ? r_main_data : '0;
    end else begin : g_bubble_raw
      assign out_data = r_main_data;
    end
  endgenerate

`ifdef PIPE_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Backpressure counter: counts cycles where a valid head is refused.
  // Saturates instead of wrapping so a long stall never reads as a short one.
  // It ignores flush and clears only on reset.
  // ---------------------------------------------------------------------------
  logic [CNT_BITS-1:0] r_stall_cnt;
  logic                w_stall;

  assign w_stall = r_main_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_BITS{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
